core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer_if.sv | 25 ++
 rtl/core_sequencer.sv | 158 +++++++++++++++
 tb/tb_core_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle for core_sequencer: instruction fetch and data access.
// A request stays high every cycle until the matching ready is seen (or the sequencer faults).
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a wait-timeout fault,
// a sticky HALT state and a free-running retired-instruction counter.
module core_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    core_sequencer_if.master        mem,
    input  logic                    RegWrite,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic                    Branch,
    input  logic                    Jal,
    input  logic                    Jalr,
    input  logic                    halt_instr,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    rf_we,
    output logic [2:0]              state,
    output logic                    halted,
    output logic                    fault,
    output logic [31:0]             retire_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        retire;

    // Branch only steers the datapath's PC mux; a branch-only instruction retires from EXEC.
    logic        unused_branch;
    assign unused_branch = Branch;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        fault_d  = fault_q;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            DECODE: begin
                state_d = halt_instr ? HALT : EXEC;
            end
            EXEC: begin
                if (MemRead && MemWrite) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (MemRead || MemWrite) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else if (RegWrite || Jal || Jalr) begin
                    state_d = WB;
                end else begin
                    retire  = 1'b1;
                end
            end
            MEM: begin
                if (mem.dmem_ready) begin
                    if (MemRead) state_d = WB;
                    else         retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
                fault_d = 1'b1;
            end
        endcase

        // Retirement is the only instruction boundary where run is honoured.
        if (retire) begin
            state_d = run ? FETCH : IDLE;
            wait_d  = '0;
        end

        retire_count_d = retire_count_q + {31'd0, retire};
        halted_d       = (state_d == HALT);
        imem_req_d     = (state_d == FETCH);
        dmem_req_d     = (state_d == MEM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            retire_count_q <= '0;
            halted_q       <= 1'b0;
            fault_q        <= 1'b0;
            imem_req_q     <= 1'b0;
            dmem_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            retire_count_q <= retire_count_d;
            halted_q       <= halted_d;
            fault_q        <= fault_d;
            imem_req_q     <= imem_req_d;
            dmem_req_q     <= dmem_req_d;
        end
    end

    assign pc_we        = retire;
    assign state        = state_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign retire_count = retire_count_q;
    assign mem.imem_req = imem_req_q;
    assign mem.dmem_req = dmem_req_q;
    assign mem.dmem_we  = dmem_req_q & MemWrite;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: random instructions with random memory wait times, scored
// per retirement against a latency/outcome model, plus directed halt, fault and wrap cases.
`timescale 1ns/1ps
module tb_core_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        reg_write, mem_read, mem_write, branch, jal, jalr, halt_instr;
    logic        ir_we, pc_we, rf_we, halted, fault;
    logic [2:0]  state;
    logic [31:0] retire_count;

    core_sequencer_if sif ();

    core_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .mem          (sif),
        .RegWrite     (reg_write),
        .MemRead      (mem_read),
        .MemWrite     (mem_write),
        .Branch       (branch),
        .Jal          (jal),
        .Jalr         (jalr),
        .halt_instr   (halt_instr),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .state        (state),
        .halted       (halted),
        .fault        (fault),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    // Expected outcome of one instruction, recorded when it is issued.
    typedef struct packed {
        logic [2:0]  st;       // state in the retire cycle
        logic        rf;       // rf_we expected with pc_we
        logic        mw;       // dmem_we level while dmem_req
        logic [3:0]  mem_cyc;  // cycles with dmem_req high
        logic [3:0]  lat;      // cycles from ir_we to pc_we inclusive
        logic [2:0]  nxt;      // state after retirement
        logic [31:0] cnt;      // retire_count seen in the retire cycle
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    logic [31:0]   exp_count;
    int            vectors;
    int            miscompares;
    int            cyc;
    int            ir_cyc;
    int            mem_cnt;
    int            retire_seen;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t cur;
        logic       pend_next;
        logic [2:0] next_exp;
        pend_next = 1'b0;
        next_exp  = 3'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                pend_next = 1'b0;
                mem_cnt   = 0;
            end else begin
                if (pend_next) begin
                    check("next_state", {29'd0, state}, {29'd0, next_exp});
                    pend_next = 1'b0;
                end
                if (ir_we) begin
                    ir_cyc  = cyc;
                    mem_cnt = 0;
                end
                if (sif.dmem_req && exp_q.size() > 0) begin
                    cur = exp_t'(exp_q[0]);
                    mem_cnt++;
                    check("dmem_we", {31'd0, sif.dmem_we}, {31'd0, cur.mw});
                end
                if (pc_we) begin
                    retire_seen++;
                    if (exp_q.size() == 0) begin
                        note_fail("unexpected_retire");
                    end else begin
                        cur = exp_t'(exp_q.pop_front());
                        check("retire_state", {29'd0, state}, {29'd0, cur.st});
                        check("rf_we", {31'd0, rf_we}, {31'd0, cur.rf});
                        check("ir_we_with_pc_we", {31'd0, ir_we}, 32'd0);
                        check("latency", 32'(cyc - ir_cyc + 1), {28'd0, cur.lat});
                        check("dmem_cycles", 32'(mem_cnt), {28'd0, cur.mem_cyc});
                        check("retire_count", retire_count, cur.cnt);
                        next_exp  = cur.nxt;
                        pend_next = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit dmem, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((!dmem && sif.imem_req) || (dmem && sif.dmem_req)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) note_fail(dmem ? "dmem_req_wait" : "imem_req_wait");
    endtask

    task automatic set_flags(input bit rw, input bit mr, input bit mw, input bit br,
                             input bit j, input bit jr, input bit hi);
        reg_write  = rw;
        mem_read   = mr;
        mem_write  = mw;
        branch     = br;
        jal        = j;
        jalr       = jr;
        halt_instr = hi;
    endtask

    task automatic fetch(input int di, output bit ok);
        wait_req(1'b0, ok);
        if (ok) begin
            repeat (di) tick();
            sif.imem_ready = 1'b1;
            tick();
            sif.imem_ready = 1'b0;
        end
    endtask

    task automatic run_instr(input bit rw, input bit mr, input bit mw, input bit br,
                             input bit j, input bit jr, input int di, input int dd,
                             input bit drop_run);
        exp_t e;
        bit   ok;
        bit   mem_op;
        bit   wb;
        int   target;
        run = 1'b1;
        set_flags(rw, mr, mw, br, j, jr, 1'b0);
        mem_op    = mr | mw;
        wb        = mr | (!mem_op && (rw | j | jr));
        e.st      = wb ? 3'd5 : (mem_op ? 3'd4 : 3'd3);
        e.rf      = wb;
        e.mw      = mw;
        e.mem_cyc = mem_op ? 4'(dd + 1) : 4'd0;
        e.lat     = 4'(3 + (mem_op ? dd + 1 : 0) + (wb ? 1 : 0));
        e.nxt     = drop_run ? 3'd0 : 3'd1;
        e.cnt     = exp_count;
        exp_q.push_back(EW'(e));
        exp_count = exp_count + 32'd1;
        target    = retire_seen + 1;

        fetch(di, ok);
        if (drop_run) run = 1'b0;
        if (ok && mem_op) begin
            wait_req(1'b1, ok);
            if (ok) begin
                repeat (dd) tick();
                sif.dmem_ready = 1'b1;
                tick();
                sif.dmem_ready = 1'b0;
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (retire_seen >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) note_fail("retire_wait");
        run = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        sif.imem_ready = 1'b0;
        sif.dmem_ready = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0, 0);
        exp_q.delete();
        exp_count = 32'd0;
        repeat (2) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_halted_fault", {30'd0, halted, fault}, 32'd0);
        check("rst_count", retire_count, 32'd0);
        check("rst_reqs", {29'd0, sif.imem_req, sif.dmem_req, sif.dmem_we}, 32'd0);
        check("rst_strobes", {29'd0, ir_we, pc_we, rf_we}, 32'd0);
        reset = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        ir_cyc      = 0;
        mem_cnt     = 0;
        retire_seen = 0;
        exp_count   = 32'd0;
        reset       = 1'b0;
        run         = 1'b0;
        sif.imem_ready = 1'b0;
        sif.dmem_ready = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0, 0);
        #12;
        do_reset();

        // Held idle until run rises.
        repeat (3) tick();
        check("idle_without_run", {29'd0, state, sif.imem_req}, 32'd0);

        // Directed: ALU op, slow load, store, branch-only, jal.
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 1, 0, 0, 0, 0, 0, 3, 0);
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 1, 0, 0, 2, 0, 0);
        run_instr(0, 0, 0, 0, 1, 0, 1, 0, 1);

        // Random mix; MemRead and MemWrite never together here.
        for (int k = 0; k < 40; k++) begin
            bit rw, mr, mw;
            rw = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            mw = mr ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr(rw, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0));
        end
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 1);
        check("count_after_random", retire_count, exp_count);

        // Counter wrap from all-ones.
        run = 1'b0;
        force dut.retire_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.retire_count_q;
        exp_count = 32'hFFFF_FFFF;
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("count_wrap", retire_count, 32'd0);

        // MemRead with MemWrite faults from EXEC.
        run = 1'b1;
        set_flags(1, 1, 1, 0, 0, 0, 0);
        fetch(0, ok);
        tick();
        tick();
        check("rdwr_fault", {29'd0, state, halted, fault}, {27'd0, 3'd6, 1'b1, 1'b1});
        do_reset();

        // Halt instruction: clean halt, sticky through run toggles.
        run = 1'b1;
        set_flags(0, 0, 0, 0, 0, 0, 1);
        fetch(0, ok);
        tick();
        check("halt_instr", {29'd0, state, halted, fault}, {27'd0, 3'd6, 1'b1, 1'b0});
        run = 1'b0;
        repeat (2) tick();
        run = 1'b1;
        repeat (2) tick();
        check("halt_sticky", {29'd0, state, halted}, {28'd0, 3'd6, 1'b1});
        do_reset();

        // Fetch timeout with imem_ready held low.
        run = 1'b1;
        wait_req(1'b0, ok);
        n = 0;
        while (sif.imem_req && n < 40) begin
            n++;
            tick();
        end
        check("fetch_timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("fetch_timeout_halt", {29'd0, state, halted, fault}, {27'd0, 3'd6, 1'b1, 1'b1});
        tick();
        check("fetch_timeout_req_low", {31'd0, sif.imem_req}, 32'd0);
        do_reset();

        // Asynchronous reset in the middle of a pending load.
        run = 1'b1;
        set_flags(1, 1, 0, 0, 0, 0, 0);
        fetch(0, ok);
        wait_req(1'b1, ok);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_mem_reset", {26'd0, state, sif.dmem_req, pc_we, rf_we}, 32'd0);
        check("mid_mem_reset_count", retire_count, 32'd0);
        do_reset();
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(1, 1, 0, 0, 0, 0, 0, 0, 1);
        check("count_after_reset", retire_count, exp_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
